aes_word_loader: RTL

Sequential front/back end for the combinational AES-128 encryption core. Collects a 128-bit plaintext and a 128-bit cipher key as eight 32-bit words over a valid/ready stream and presents them to the core's `InputMessage`/`CipherKey` inputs. It waits a fixed number of cycles for the core's long combinational path to settle, registers `CodedMessage`, and streams the ciphertext back out as four 32-bit words. It sits directly around the encryption core: upstream of its inputs and downstream of its output.

---
 rtl/aes_word_loader_if.sv | 24 ++
 rtl/aes_word_loader.sv | 91 +++++++++
 2 files changed

// File: rtl/aes_word_loader_if.sv
// Word-stream and core-facing signals of the AES word loader.
// The slave modport is the loader; the master modport is its environment.
interface aes_word_loader_if;
  logic [31:0]  InWord;
  logic         InValid;
  logic         InReady;
  logic [127:0] InputMessage;
  logic [127:0] CipherKey;
  logic [127:0] CodedMessage;
  logic [31:0]  OutWord;
  logic         OutValid;
  logic         OutReady;
  logic         Busy;

  modport slave (
    input  InWord, InValid, CodedMessage, OutReady,
    output InReady, InputMessage, CipherKey, OutWord, OutValid, Busy
  );

  modport master (
    output InWord, InValid, CodedMessage, OutReady,
    input  InReady, InputMessage, CipherKey, OutWord, OutValid, Busy
  );
endinterface

// File: rtl/aes_word_loader.sv
// Loads message and key as eight words for a combinational AES-128 core.
// It then waits a fixed settle time and streams the ciphertext out as four words.
module aes_word_loader #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic Clk,
  input logic Reset,
  aes_word_loader_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } state_t;

  localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

  state_t        state;
  state_t        stateNext;
  logic [2:0]    wcnt;
  logic [1:0]    ocnt;
  logic [7:0]    scnt;
  logic [255:0]  blockReg;
  logic [127:0]  result;
  logic [31:0]   outMux;

  // Next-state decode; only registered state and the two valid/ready inputs matter.
  always_comb begin
    stateNext = state;
    unique case (state)
      LOAD:    if (bus.InValid && (wcnt == 3'd7)) stateNext = SETTLE;
      SETTLE:  if (scnt == SettleLast) stateNext = SEND;
      SEND:    if (bus.OutReady && (ocnt == 2'd3)) stateNext = LOAD;
      default: stateNext = LOAD;
    endcase
  end

  // ocnt parks on the last word after a block so OutWord keeps its final value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= LOAD;
      wcnt     <= 3'd0;
      ocnt     <= 2'd0;
      scnt     <= 8'd0;
      blockReg <= '0;
      result   <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        LOAD: begin
          if (bus.InValid) begin
            blockReg <= {blockReg[223:0], bus.InWord};
            wcnt     <= wcnt + 3'd1;
            if (wcnt == 3'd7) scnt <= 8'd0;
          end
        end
        SETTLE: begin
          scnt <= scnt + 8'd1;
          if (scnt == SettleLast) begin
            result <= bus.CodedMessage;
            ocnt   <= 2'd0;
          end
        end
        SEND: begin
          if (bus.OutReady && (ocnt != 2'd3)) ocnt <= ocnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    outMux = result[127:96];
    unique case (ocnt)
      2'd0: outMux = result[127:96];
      2'd1: outMux = result[95:64];
      2'd2: outMux = result[63:32];
      2'd3: outMux = result[31:0];
      default: outMux = result[127:96];
    endcase
  end

  assign bus.InReady      = (state == LOAD);
  assign bus.OutValid     = (state == SEND);
  assign bus.Busy         = (state != LOAD) || (wcnt != 3'd0);
  assign bus.InputMessage = blockReg[255:128];
  assign bus.CipherKey    = blockReg[127:0];
  assign bus.OutWord      = outMux;

endmodule
